// File: rtl/fxp_mul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_mul_pipe_if
//  Purpose  : Sample/mode/result bundle of the pipelined fixed-point multiplier.
//             The master drives operands and modes; the slave returns results.
//  Revision : 1.0  initial release
// ============================================================================
interface fxp_mul_pipe_if #(
  parameter int NB_A   = 16,
  parameter int NB_B   = 12,
  parameter int NB_OUT = 9,
  parameter int NB_CNT = 16
);
  logic                   i_valid;
  logic [NB_A-1:0]        i_A;
  logic [NB_B-1:0]        i_B;
  logic                   i_round;
  logic                   i_sat;
  logic                   i_clr_cnt;
  logic                   o_valid;
  logic [NB_A+NB_B-1:0]   o_full;
  logic [NB_OUT-1:0]      o_q;
  logic                   o_ovf;
  logic [NB_CNT-1:0]      o_ovf_cnt;

  modport master (
    output i_valid, i_A, i_B, i_round, i_sat, i_clr_cnt,
    input  o_valid, o_full, o_q, o_ovf, o_ovf_cnt
  );

  modport slave (
    input  i_valid, i_A, i_B, i_round, i_sat, i_clr_cnt,
    output o_valid, o_full, o_q, o_ovf, o_ovf_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_mul_pipe
//  Purpose  : Three-stage signed fixed-point multiplier S(NB_A,NBF_A) x
//             S(NB_B,NBF_B) with per-sample truncate/round and wrap/saturate
//             modes, an overflow flag and a saturating overflow-event counter.
//  Revision : 1.0  initial release
// ============================================================================
module fxp_mul_pipe #(
  parameter int NB_A    = 16,
  parameter int NBF_A   = 14,
  parameter int NB_B    = 12,
  parameter int NBF_B   = 11,
  parameter int NB_OUT  = 9,
  parameter int NBF_OUT = 8,
  parameter int NB_CNT  = 16
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst_n,
  fxp_mul_pipe_if.slave bus
);

  // Full-precision product format and the number of dropped LSBs.
  localparam int NB_P  = NB_A + NB_B;
  localparam int NBF_P = NBF_A + NBF_B;
  localparam int D     = NBF_P - NBF_OUT;
  // Quantised intermediate keeps one guard bit above the product so the
  // rounding increment can never wrap before the range check.
  localparam int NB_I  = NB_P + 1 - D;

  localparam logic [NB_OUT-1:0] C_Q_MAX   = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic [NB_OUT-1:0] C_Q_MIN   = {1'b1, {(NB_OUT-1){1'b0}}};
  localparam logic [NB_CNT-1:0] C_CNT_MAX = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] C_CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  // Stage 1: operand and mode capture.
  logic [NB_A-1:0] r_s1_a;
  logic [NB_B-1:0] r_s1_b;
  logic            r_s1_round;
  logic            r_s1_sat;
  logic            r_s1_valid;

  // Stage 2: full product plus travelling modes.
  logic [NB_P-1:0] r_s2_prod;
  logic            r_s2_round;
  logic            r_s2_sat;
  logic            r_s2_valid;

  // Stage 3: quantised outputs.
  logic              r_valid;
  logic [NB_P-1:0]   r_full;
  logic [NB_OUT-1:0] r_q;
  logic              r_ovf;
  logic [NB_CNT-1:0] r_ovf_cnt;

  // Combinational datapath signals.
  logic [NB_P-1:0]   w_a_ext;
  logic [NB_P-1:0]   w_b_ext;
  logic [NB_P-1:0]   w_prod;
  logic [NB_P:0]     w_prod_ext;
  logic [NB_I-1:0]   w_int;
  logic              w_ovf;
  logic [NB_OUT-1:0] w_q;
  logic              w_event;

  // Capture operands and modes every cycle; only the valid bit is qualified.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_round <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_a     <= bus.i_A;
      r_s1_b     <= bus.i_B;
      r_s1_round <= bus.i_round;
      r_s1_sat   <= bus.i_sat;
      r_s1_valid <= bus.i_valid;
    end
  end

  // Both operands are sign-extended to the product width so the multiply is
  // a same-width signed operation; -2^(NB_A-1) * -2^(NB_B-1) still fits.
  assign w_a_ext = {{NB_B{r_s1_a[NB_A-1]}}, r_s1_a};
  assign w_b_ext = {{NB_A{r_s1_b[NB_B-1]}}, r_s1_b};
  assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);

  // Register the full-precision product alongside its modes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_prod  <= '0;
      r_s2_round <= 1'b0;
      r_s2_sat   <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_prod  <= w_prod;
      r_s2_round <= r_s1_round;
      r_s2_sat   <= r_s1_sat;
      r_s2_valid <= r_s1_valid;
    end
  end

  assign w_prod_ext = {r_s2_prod[NB_P-1], r_s2_prod};

  // Dropping the low D bits of a two's-complement value is a floor shift;
  // rounding half up is the same shift after adding half an output LSB.
  generate
    if (D > 0) begin : g_round
      localparam logic [NB_P:0] C_HALF = (NB_P+1)'(1) << (D - 1);
      logic [NB_P:0] w_biased;
      logic          w_unused_lsbs;
      assign w_biased      = w_prod_ext + (r_s2_round ? C_HALF : '0);
      assign w_int         = w_biased[NB_P:D];
      assign w_unused_lsbs = ^w_biased[D-1:0];
    end else begin : g_no_round
      assign w_int = w_prod_ext;
    end
  endgenerate

  // In range only if every bit above the output sign bit equals it.
  assign w_ovf = !((&w_int[NB_I-1:NB_OUT-1]) || !(|w_int[NB_I-1:NB_OUT-1]));

  // Saturate picks the rail on the side of the true sign; wrap keeps low bits.
  always_comb begin
    w_q = w_int[NB_OUT-1:0];
    if (w_ovf && r_s2_sat) begin
      w_q = w_int[NB_I-1] ? C_Q_MIN : C_Q_MAX;
    end
  end

  assign w_event = r_s2_valid && w_ovf;

  // Output stage; the overflow flag is only meaningful on valid samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_full  <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= r_s2_valid;
      r_full  <= r_s2_prod;
      r_q     <= w_q;
      r_ovf   <= w_event;
    end
  end

  // Overflow-event counter: a clear that coincides with an event keeps that
  // event, so no overflow is ever lost across a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= '0;
    end else if (bus.i_clr_cnt) begin
      r_ovf_cnt <= w_event ? C_CNT_ONE : '0;
    end else if (w_event && (r_ovf_cnt != C_CNT_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + C_CNT_ONE;
    end
  end

  assign bus.o_valid   = r_valid;
  assign bus.o_full    = r_full;
  assign bus.o_q       = r_q;
  assign bus.o_ovf     = r_ovf;
  assign bus.o_ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fxp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fxp_mul_pipe
//  Purpose  : Scoreboard bench for fxp_mul_pipe with an arithmetic reference
//             model; a second instance with a 2-bit counter exercises the
//             counter saturation rail.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fxp_mul_pipe;
  localparam int NB_A = 16, NBF_A = 14, NB_B = 12, NBF_B = 11;
  localparam int NB_OUT = 9, NBF_OUT = 8, NB_CNT = 16, NB_CNT2 = 2;
  localparam int D = NBF_A + NBF_B - NBF_OUT;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  fxp_mul_pipe_if #(.NB_A(NB_A), .NB_B(NB_B), .NB_OUT(NB_OUT), .NB_CNT(NB_CNT))  bus ();
  fxp_mul_pipe_if #(.NB_A(NB_A), .NB_B(NB_B), .NB_OUT(NB_OUT), .NB_CNT(NB_CNT2)) bus2 ();

  assign bus2.i_valid   = bus.i_valid;
  assign bus2.i_A       = bus.i_A;
  assign bus2.i_B       = bus.i_B;
  assign bus2.i_round   = bus.i_round;
  assign bus2.i_sat     = bus.i_sat;
  assign bus2.i_clr_cnt = bus.i_clr_cnt;

  fxp_mul_pipe #(.NB_A(NB_A), .NBF_A(NBF_A), .NB_B(NB_B), .NBF_B(NBF_B),
                 .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT), .NB_CNT(NB_CNT))
    dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  fxp_mul_pipe #(.NB_A(NB_A), .NBF_A(NBF_A), .NB_B(NB_B), .NBF_B(NBF_B),
                 .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT), .NB_CNT(NB_CNT2))
    dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus2));

  typedef struct {
    int     cyc;
    longint full;
    longint q;
    bit     ovf;
  } exp_t;

  exp_t   sbq[$];
  int     n_pass  = 0;
  int     n_total = 0;
  int     cyc     = 0;
  bit     clr_seen = 1'b0;
  longint cnt_m   = 0;
  longint cnt2_m  = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Reference: real-valued product scaled to output LSBs, floored, then
  // range-limited by clamping or by keeping it modulo 2^NB_OUT.
  function automatic exp_t model(logic [NB_A-1:0] a_bits, logic [NB_B-1:0] b_bits,
                                 bit rnd, bit sat, int at_cyc);
    exp_t   e;
    int     av, bv;
    longint p, scale, num, q, lo, hi, qo;
    av    = $signed(a_bits);
    bv    = $signed(b_bits);
    p     = longint'(av) * longint'(bv);
    scale = longint'(1) << D;
    num   = rnd ? p + scale / 2 : p;
    q     = num / scale;
    if (num < 0 && q * scale != num) q = q - 1;
    lo    = -(longint'(1) << (NB_OUT - 1));
    hi    = (longint'(1) << (NB_OUT - 1)) - 1;
    e.ovf = (q < lo) || (q > hi);
    qo    = (sat && e.ovf) ? ((q > hi) ? hi : lo) : q;
    e.q   = qo & ((longint'(1) << NB_OUT) - 1);
    e.full = p & ((longint'(1) << (NB_A + NB_B)) - 1);
    e.cyc = at_cyc + 3;
    return e;
  endfunction

  // Drive one input slot just after a rising edge.
  task automatic send(bit v, logic [NB_A-1:0] a, logic [NB_B-1:0] b,
                      bit rnd, bit sat, bit clr);
    @(posedge i_clk);
    #1;
    bus.i_valid   = v;
    bus.i_A       = a;
    bus.i_B       = b;
    bus.i_round   = rnd;
    bus.i_sat     = sat;
    bus.i_clr_cnt = clr;
    if (v) sbq.push_back(model(a, b, rnd, sat, cyc));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) send(1'b0, 16'($urandom), 12'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // Cycle index and the clear value seen by the counter at each edge.
  always @(posedge i_clk) begin
    cyc++;
    clr_seen = bus.i_clr_cnt;
  end

  // Monitor: pops the scoreboard whenever an output is due and tracks the counter.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      bit   exp_v;
      bit   ev;
      exp_t e;
      ev = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        chk("lost_sample", 64'(e.cyc), 64'(cyc));
      end
      exp_v = (sbq.size() > 0) && (sbq[0].cyc == cyc);
      chk("o_valid", 64'(bus.o_valid), 64'(exp_v));
      chk("o_valid_cnt2", 64'(bus2.o_valid), 64'(exp_v));
      if (exp_v) begin
        e  = sbq.pop_front();
        ev = e.ovf;
        chk("o_full", 64'(bus.o_full), e.full);
        chk("o_q", 64'(bus.o_q), e.q);
        chk("o_ovf", 64'(bus.o_ovf), 64'(e.ovf));
      end else begin
        chk("o_ovf_idle", 64'(bus.o_ovf), 64'd0);
      end
      if (clr_seen) begin
        cnt_m  = ev ? 1 : 0;
        cnt2_m = ev ? 1 : 0;
      end else if (ev) begin
        if (cnt_m  < (longint'(1) << NB_CNT)  - 1) cnt_m++;
        if (cnt2_m < (longint'(1) << NB_CNT2) - 1) cnt2_m++;
      end
      chk("o_ovf_cnt", 64'(bus.o_ovf_cnt), cnt_m);
      chk("o_ovf_cnt_w2", 64'(bus2.o_ovf_cnt), cnt2_m);
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_full"},  64'(bus.o_full),  64'd0);
    chk({tag, "_q"},     64'(bus.o_q),     64'd0);
    chk({tag, "_ovf"},   64'(bus.o_ovf),   64'd0);
    chk({tag, "_cnt"},   64'(bus.o_ovf_cnt), 64'd0);
    chk({tag, "_cnt2"},  64'(bus2.o_ovf_cnt), 64'd0);
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_A = '0; bus.i_B = '0;
    bus.i_round = 1'b0; bus.i_sat = 1'b0; bus.i_clr_cnt = 1'b0;

    // Power-on reset.
    #1 i_rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    idle(2);

    // Directed products, overflow and rounding corners.
    send(1, 16'h2000, 12'h400, 0, 1, 0);
    send(1, 16'h6000, 12'h600, 0, 1, 0);
    send(1, 16'h6000, 12'h600, 0, 0, 0);
    send(1, 16'h8000, 12'h400, 0, 1, 0);
    send(1, 16'h8000, 12'h600, 0, 1, 0);
    send(1, 16'h8000, 12'h800, 0, 1, 0);
    send(1, 16'h0040, 12'h400, 0, 1, 0);
    send(1, 16'h0040, 12'h400, 1, 1, 0);
    send(1, 16'hFFC0, 12'h400, 0, 1, 0);
    send(1, 16'hFFC0, 12'h400, 1, 1, 0);
    send(1, 16'h3FFF, 12'h7FF, 1, 1, 0);
    send(1, 16'h3FFF, 12'h7FF, 1, 0, 0);
    idle(4);

    // Random stream with per-sample mode toggling and a 2-cycle gap.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) idle(2);
      send(1, 16'($urandom), 12'($urandom), i[0], i[1], ($urandom_range(0, 31) == 0));
    end
    idle(4);

    // Clear coinciding with an overflow event, then a clear on its own.
    send(1, 16'h6000, 12'h600, 0, 1, 0);
    send(0, 16'h0000, 12'h000, 0, 0, 0);
    send(0, 16'h0000, 12'h000, 0, 0, 1);
    idle(2);
    send(0, 16'h0000, 12'h000, 0, 0, 1);
    idle(2);

    // Reset while two samples are in flight.
    send(1, 16'h6000, 12'h600, 0, 1, 0);
    send(1, 16'h2000, 12'h400, 0, 1, 0);
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    bus.i_valid = 1'b0;
    #1 check_zero("midreset");
    sbq.delete();
    cnt_m  = 0;
    cnt2_m = 0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    idle(6);

    chk("drain", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
